// File: rtl/nios2_c_cpu_mul_pkg.sv
// nios2_c_cpu_mul_pkg: shared constants and state encoding for the iterative multiplier
package nios2_c_cpu_mul_pkg;
    localparam int LANE_W = 16;
    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXSS = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXUU = 2'd3;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_t;
endpackage

// File: rtl/nios2_c_cpu_mul_lane.sv
// nios2_c_cpu_mul_lane: combinational unsigned LANE_W x LANE_W partial-product multiplier
module nios2_c_cpu_mul_lane
    import nios2_c_cpu_mul_pkg::*;
(
    input  logic [LANE_W-1:0]   a,
    input  logic [LANE_W-1:0]   b,
    output logic [2*LANE_W-1:0] p
);
    assign p = a * b;
endmodule

// File: rtl/nios2_c_cpu_mul_seq.sv
// nios2_c_cpu_mul_seq: iterative mul/mulxss/mulxsu/mulxuu unit, one partial product per cycle;
// defining NIOS2_C_MUL_EARLY_OUT_EN skips accumulation when either magnitude is zero
module nios2_c_cpu_mul_seq
    import nios2_c_cpu_mul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              A_mul_start,
    input  logic [1:0]        A_mul_op,
    input  logic [DATA_W-1:0] A_mul_src1,
    input  logic [DATA_W-1:0] A_mul_src2,
    input  logic              A_mul_flush,
    output logic              A_mul_busy,
    output logic              A_mul_done,
    output logic [DATA_W-1:0] A_mul_result
);
    localparam int N = DATA_W / LANE_W;
    localparam int K = N * N;
    localparam int CNT_W = K > 1 ? $clog2(K) : 1;

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, ia, ib;
    logic [2*DATA_W-1:0] acc, p;
    logic [DATA_W-1:0] a_mag, b_mag, mag1, mag2;
    logic [2*LANE_W-1:0] prod;
    logic [1:0] op_q;
    logic neg, s1neg, s2neg, early, accept, fix_fire, last;

    assign s1neg = (A_mul_op == OP_MULXSS || A_mul_op == OP_MULXSU) && A_mul_src1[DATA_W-1];
    assign s2neg = A_mul_op == OP_MULXSS && A_mul_src2[DATA_W-1];
    assign mag1 = s1neg ? -A_mul_src1 : A_mul_src1;
    assign mag2 = s2neg ? -A_mul_src2 : A_mul_src2;
`ifdef NIOS2_C_MUL_EARLY_OUT_EN
    assign early = mag1 == '0 || mag2 == '0;
`else
    assign early = 1'b0;
`endif
    assign accept = state == S_IDLE && A_mul_start && !A_mul_flush;
    assign fix_fire = state == S_FIX && !A_mul_flush;
    assign last = cnt == CNT_W'(K - 1);
    assign ia = CNT_W'(cnt % N);
    assign ib = CNT_W'(cnt / N);
    assign p = neg ? -acc : acc;
    assign A_mul_busy = state != S_IDLE;

    nios2_c_cpu_mul_lane u_lane (
        .a(a_mag[ia*LANE_W +: LANE_W]),
        .b(b_mag[ib*LANE_W +: LANE_W]),
        .p(prod)
    );

    // Next-state: flush always returns to IDLE and beats a simultaneous start
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = accept ? (early ? S_FIX : S_MUL) : S_IDLE;
            S_MUL:   state_nxt = A_mul_flush ? S_IDLE : (last ? S_FIX : S_MUL);
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, operand latch, accumulation and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            acc          <= '0;
            a_mag        <= '0;
            b_mag        <= '0;
            neg          <= 1'b0;
            op_q         <= OP_MUL;
            A_mul_done   <= 1'b0;
            A_mul_result <= '0;
        end else begin
            state      <= state_nxt;
            A_mul_done <= fix_fire;
            if (accept) begin
                a_mag <= mag1;
                b_mag <= mag2;
                neg   <= s1neg ^ s2neg;
                op_q  <= A_mul_op;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == S_MUL) begin
                acc <= acc + ((2*DATA_W)'(prod) << (LANE_W * (ia + ib)));
                cnt <= last ? cnt : cnt + 1'b1;
            end
            if (fix_fire)
                A_mul_result <= op_q == OP_MUL ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W];
        end
    end
endmodule

// File: tb/tb_nios2_c_cpu_mul_seq.sv
// tb_nios2_c_cpu_mul_seq: directed table and corner-case sequences for the iterative multiplier
module tb_nios2_c_cpu_mul_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1, src2;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[13];

    nios2_c_cpu_mul_seq #(.DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .A_mul_start(start), .A_mul_op(op),
        .A_mul_src1(src1), .A_mul_src2(src2), .A_mul_flush(flush),
        .A_mul_busy(busy), .A_mul_done(done), .A_mul_result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef NIOS2_C_MUL_EARLY_OUT_EN
        return (a == 0 || b == 0) ? 2 : 6;
`else
        return 6;
`endif
    endfunction

    // Drive a one-cycle start at the current negedge, then scramble inputs after acceptance
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); src1 = $urandom; src2 = $urandom;
    endtask

    task automatic wait_done(input string nm, input int lat, input logic [31:0] exp);
        int c = 1;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk({nm, " done"}, 64'(done), 64'd1);
        chk({nm, " latency"}, 64'(c), 64'(lat));
        chk({nm, " result"}, 64'(result), 64'(exp));
    endtask

    task automatic no_done(input string nm, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk({nm, " no done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'h00010002, 32'h00030004, 32'h000A0008};
        vecs[1]  = '{2'd3, 32'h00010002, 32'h00030004, 32'h00000003};
        vecs[2]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[3]  = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[4]  = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[6]  = '{2'd2, 32'h80000000, 32'h80000000, 32'hC0000000};
        vecs[7]  = '{2'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[8]  = '{2'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[9]  = '{2'd2, 32'h00000005, 32'hFFFFFFFF, 32'h00000004};
        vecs[10] = '{2'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
        vecs[11] = '{2'd1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
        vecs[12] = '{2'd0, 32'h00000000, 32'h00001234, 32'h00000000};
        reset_n = 1'b0; start = 1'b0; op = 2'd0; src1 = '0; src2 = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        foreach (vecs[i]) begin
            start_op(vecs[i].op, vecs[i].s1, vecs[i].s2);
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'd1);
            wait_done($sformatf("vec%0d", i), exp_lat(vecs[i].s1, vecs[i].s2), vecs[i].exp);
            @(negedge clk);
            chk($sformatf("vec%0d done pulse", i), 64'(done), 64'd0);
        end
        start_op(2'd1, 32'h80000000, 32'h80000000);
        wait_done("xss min", 6, 32'h40000000);
        start_op(2'd0, 32'h00010002, 32'h00030004);
        wait_done("b2b", 6, 32'h000A0008);
        @(negedge clk);
        start_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        op = 2'd0; src1 = 32'h1; src2 = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        no_done("flush", 8);
        chk("flush result", 64'(result), 64'h000A0008);
        op = 2'd3; src1 = 32'h5; src2 = 32'h5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush+start busy", 64'(busy), 64'd0);
        no_done("flush+start", 8);
        start_op(2'd3, 32'h12345678, 32'h9ABCDEF0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst done", 64'(done), 64'd0);
        chk("async rst result", 64'(result), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        no_done("post reset", 8);
        start_op(2'd3, 32'h00010002, 32'h00030004);
        wait_done("after reset", 6, 32'h00000003);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nios2_c_cpu_mul_seq.md
# nios2_c_cpu_mul_seq

Iterative, parametrised multiply unit for the nios2_c CPU A-stage. It supports `mul`, `mulxss`, `mulxsu` and `mulxuu`. Each product is built from 16x16 unsigned partial products, accumulated one per cycle, with sign correction at the end. It replaces the fixed 32-bit low-word-only multiplier cell and adds high-word results, signed modes, a start/done handshake and an abort path.

## Interface
- `DATA_W`, 32: operand/result width; multiple of 16, range 16..64.
- `LANE_W`, 16: partial-product lane width; fixed, exported from the package.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `A_mul_start` in 1: request; sampled only in IDLE.
- `A_mul_op` in 2: 0=MUL (low word), 1=MULXSS, 2=MULXSU, 3=MULXUU (high word).
- `A_mul_src1` in DATA_W: multiplicand; signed for MULXSS/MULXSU.
- `A_mul_src2` in DATA_W: multiplier; signed for MULXSS only.
- `A_mul_flush` in 1: abort the operation in flight.
- `A_mul_busy` out 1: operation in flight (MUL or FIX state).
- `A_mul_done` out 1: one-cycle pulse; result valid.
- `A_mul_result` out DATA_W: registered result; holds until the next done.

## Operation
- States are IDLE, MUL and FIX. Define N=DATA_W/16 and K=N*N.
- IDLE with `A_mul_start`=1:
  - Latch magnitudes |src1| and |src2|. A magnitude is taken only where the operand is signed and negative.
  - Latch neg = s1neg XOR s2neg, and latch the op.
  - Clear the 2*DATA_W accumulator and set counter i=0. Go to MUL.
- MUL, each cycle: acc += lane(a_i, b_j) << 16*(i_a+i_b).
  - i_a = i mod N, i_b = i div N.
  - After the addition with i=K-1, go to FIX.
- FIX:
  - p = neg ? -acc : acc, computed in 2*DATA_W two's complement.
  - `A_mul_result` = op==MUL ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W].
  - Pulse `A_mul_done` and go to IDLE.
- Magnitude of the most-negative value (e.g. 0x80000000) is 2^(DATA_W-1). It is held as unsigned DATA_W with no overflow.
- MUL op ignores signedness; its low word is identical for all modes.
- `A_mul_start` while busy is ignored, with no queueing. Start in the done cycle is accepted (state is IDLE).
- `A_mul_flush` in MUL or FIX: go to IDLE next edge, no done pulse, `A_mul_result` unchanged.
- Flush and start in the same cycle in IDLE: flush wins and start is dropped.
- `A_mul_op`/src changes after acceptance have no effect.

## Timing
- Reset values:
  - `A_mul_busy`=0, `A_mul_done`=0, `A_mul_result`=0.
  - State IDLE, accumulator 0, counter 0.
- Start sampled at the end of cycle t. Then:
  - `A_mul_busy`=1 in cycles t+1..t+K+1.
  - `A_mul_done`=1 in cycle t+K+2 only.
  - Latency is 6 cycles for DATA_W=32.
- Throughput is one operation per K+2 cycles with back-to-back starts.
- Reset asserted mid-operation clears everything immediately and asynchronously. No done is produced.
- Flush asserted in cycle c gives `A_mul_busy`=0 from cycle c+1.

## Configuration
- `NIOS2_C_MUL_EARLY_OUT_EN` defined:
  - If either latched magnitude is zero at acceptance, skip MUL and enter FIX directly, with acc=0.
  - done then arrives at t+2 with result 0.
  - `A_mul_busy` is high for cycle t+1 only.
- Undefined: all operations take K+2 cycles regardless of operand values.

## Structure
- Package `nios2_c_cpu_mul_pkg` holds:
  - op encoding constants (OP_MUL, OP_MULXSS, OP_MULXSU, OP_MULXUU);
  - state enum;
  - `LANE_W`.
- Sub-module `nios2_c_cpu_mul_lane`: combinational 16x16 unsigned multiplier with 32-bit output. It is instantiated once and shared across iterations.

## Test plan
- MUL, 0x00010002 x 0x00030004 -> result 0x000A0008 at t+6. Same operands with MULXUU -> 0x00000003.
- 0xFFFFFFFF x 0xFFFFFFFF, each mode:
  - MULXSS -> 0x00000000;
  - MULXUU -> 0xFFFFFFFE;
  - MULXSU -> 0xFFFFFFFF;
  - MUL -> 0x00000001.
- MULXSS 0x80000000 x 0x80000000 -> 0x40000000. Then start again in the done cycle -> accepted, second done exactly 6 cycles later.
- Flush at t+3:
  - no done pulse; busy low at t+4; result keeps its prior value.
  - A start pulsed during busy is ignored.
- `reset_n` low at t+2 -> outputs 0 immediately, no done. Start after release completes normally.
- src1=0, src2=0x1234, MUL:
  - with `NIOS2_C_MUL_EARLY_OUT_EN`, done at t+2, result 0;
  - without it, done at t+6, result 0.
